prio_q_sched: RTL
=================

# prio_q_sched

Scheduler sitting in front of the event priority queue in the PDES core. It arbitrates enqueue requests from `NC` simulation cores round-robin and serves one dequeue consumer, the event dispatcher. It issues at most one queue operation per cycle and enforces full/empty limits and the post-dequeue bubble the heap pipeline needs. Optionally it also keeps performance counters.

## Interface
Parameters:
- `NC`, 4: number of enqueuing cores (2..8).
- `DW`, 64: event word width (matches queue `DW`).
- `HD`, 5: heap depth. Capacity `CAP = 2^HD - 1` = 31.
- `DEQ_GAP`, 1: idle cycles forced after every dequeue (0..3).

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enq_valid`, in, NC: per-core enqueue request.
- `enq_data`, in, NC*DW: per-core event; core i occupies bits `[i*DW +: DW]`.
- `enq_ready`, out, NC: one-hot grant. Core i's event is accepted in a cycle where `enq_valid[i] && enq_ready[i]`.
- `deq_valid`, out, 1: head event available.
- `deq_data`, out, DW: head event. Equals `q_out_data` combinationally.
- `deq_ready`, in, 1: dispatcher takes the head event.
- `drain`, in, 1: block new enqueues and let dequeues empty the queue.
- `drain_done`, out, 1: high while `drain` is set and the queue is empty.
- `q_enq`, out, 1: queue enqueue strobe.
- `q_deq`, out, 1: queue dequeue strobe.
- `q_inp_data`, out, DW: queue input word.
- `q_out_data`, in, DW: queue root (minimum).
- `q_count`, in, HD: queue occupancy.

## Operation
- State machine with two states, RUN and GAP. Reset enters RUN with gap counter 0.
- RUN, eligibility:
  - Enqueue is eligible when any `enq_valid` bit is set, `q_count < CAP` and `drain == 0`.
  - Dequeue is eligible when `q_count != 0`.
  - `deq_valid` = dequeue eligible.
  - `enq_ready[i]` is set only for the round-robin winner, and only when enqueue is eligible and dequeue is not chosen this cycle.
- Conflict rule: when both enqueue and dequeue are eligible and `deq_ready` is set, the toggle bit `pri` decides.
  - `pri = 0`: dequeue wins. `pri = 1`: enqueue wins.
  - `pri` flips after every contested cycle. Reset value is 0.
- Dequeue taken (`deq_valid && deq_ready` and chosen):
  - `q_deq = 1` that cycle.
  - If `DEQ_GAP > 0`, go to GAP with the counter loaded to `DEQ_GAP`.
- Enqueue taken:
  - `q_enq = 1` and `q_inp_data` = winner's data.
  - The round-robin pointer moves to winner+1 mod NC. Pointer reset value is 0.
- GAP state:
  - `deq_valid = 0`, `enq_ready = 0`, `q_enq = q_deq = 0`.
  - The counter decrements each cycle. Return to RUN when it reaches 1.
- `q_enq` and `q_deq` are never high in the same cycle. They are driven combinationally from registered state and inputs.
- `q_inp_data` is 0 whenever `q_enq = 0`.
- Full (`q_count == CAP`): all `enq_ready` bits are 0 and the round-robin pointer is frozen.
- Empty: `deq_valid = 0`.
- `drain_done = drain && q_count == 0`.
- Reset mid-operation: `rst` has priority over everything. The state returns to RUN and all strobes are 0 in the cycle `rst` is sampled. The queue must be reset in the same cycle by the integrator.

## Timing
- Grant-to-strobe latency is 0 cycles: `q_enq`/`q_deq` assert in the handshake cycle.
- `q_count` reflects an operation one cycle after its strobe. The scheduler uses `q_count` directly and never issues twice on a stale count.
- Minimum dequeue-to-next-op spacing is `DEQ_GAP + 1` cycles.
- Back-to-back enqueues are allowed every cycle.
- Reset values: `enq_ready = 0`, `deq_valid = 0`, `q_enq = 0`, `q_deq = 0`, `q_inp_data = 0`, `drain_done = 0`, `pri = 0`, round-robin pointer = 0, gap counter = 0.

## Configuration
- `PRIOQ_SCHED_STATS_EN`:
  - Defined: adds outputs `stat_enq`, `stat_deq` and `stat_full`, each 32 bits.
    - `stat_enq` counts enqueues and `stat_deq` counts dequeues.
    - `stat_full` counts cycles where `enq_valid != 0` and `q_count == CAP`.
    - All three are cleared by `rst` and saturate at `2^32 - 1`.
  - Undefined: these ports and the logic behind them are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then `enq_valid = 4'b1111` for 4 cycles: grants go to cores 0, 1, 2, 3 in order; `q_enq` is high for 4 cycles; `q_count` reaches 4.
- With `q_count = 3`, hold `deq_ready = 1` and `DEQ_GAP = 1`: `q_deq` pulses on cycles 0, 2 and 4; `deq_valid` is 0 on cycles 1, 3 and 5 onward; the queue ends empty.
- With `q_count = 31` and `enq_valid = 4'b0001`: `enq_ready` stays 0; a single dequeue lets the next eligible cycle grant core 0.
- Contested run: `enq_valid = 1`, `deq_ready = 1`, `q_count = 10`, `DEQ_GAP = 0`: dequeue wins first, then operations alternate enq, deq, enq, and so on.
- With `q_count = 5`, assert `drain` while enqueues are pending: no `q_enq`; after 5 dequeues `drain_done` rises.
- Assert `rst` in the middle of a GAP: the next cycle is RUN with all outputs at reset values; with `PRIOQ_SCHED_STATS_EN` defined, all stat counters read 0.

Source files
------------

// File: rtl/prio_q_sched_if.sv
// Bundles the scheduler's core-side, dispatcher-side and queue-side signals.
// slave = scheduler view, master = surrounding cores/dispatcher/queue view.
interface prio_q_sched_if #(
  parameter int NC = 4,
  parameter int DW = 64,
  parameter int HD = 5
);
  logic [NC-1:0]    enq_valid;
  logic [NC*DW-1:0] enq_data;
  logic [NC-1:0]    enq_ready;
  logic             deq_valid;
  logic [DW-1:0]    deq_data;
  logic             deq_ready;
  logic             drain;
  logic             drain_done;
  logic             q_enq;
  logic             q_deq;
  logic [DW-1:0]    q_inp_data;
  logic [DW-1:0]    q_out_data;
  logic [HD-1:0]    q_count;

  modport slave (
    input  enq_valid, enq_data, deq_ready, drain, q_out_data, q_count,
    output enq_ready, deq_valid, deq_data, drain_done, q_enq, q_deq, q_inp_data
  );

  modport master (
    output enq_valid, enq_data, deq_ready, drain, q_out_data, q_count,
    input  enq_ready, deq_valid, deq_data, drain_done, q_enq, q_deq, q_inp_data
  );
endinterface

// File: rtl/prio_q_sched.sv
// Round-robin enqueue / single-consumer dequeue scheduler for the PDES event heap.
// Optional performance counters enabled by defining PRIOQ_SCHED_STATS_EN.
module prio_q_sched #(
  parameter int NC      = 4,
  parameter int DW      = 64,
  parameter int HD      = 5,
  parameter int DEQ_GAP = 1
) (
  input  logic             CLK,
  input  logic             rst,
  prio_q_sched_if.slave    bus
`ifdef PRIOQ_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_enq,
  output logic [31:0]      stat_deq,
  output logic [31:0]      stat_full
`endif
);

  localparam int PW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [HD-1:0] CAP = '1;

  typedef enum logic {RUN, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gap_cnt_q, gap_cnt_d;
  logic          pri_q, pri_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand_idx;
  logic          run, full;
  logic          enq_elig, deq_elig, contested;
  logic          enq_take, deq_take;
  logic [NC-1:0] enq_ready_w;
  logic [DW-1:0] inp_data_w;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pri_d     = pri_q;
    rr_ptr_d  = rr_ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    enq_ready_w = '0;
    inp_data_w  = '0;

    // first requesting core at or after the pointer, wrapping at NC
    for (int unsigned i = 0; i < NC; i++) begin
      cand_idx = PW'((32'(rr_ptr_q) + i) % NC);
      if (!win_found && bus.enq_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end

    run       = (state_q == RUN) && !rst;
    full      = (bus.q_count == CAP);
    enq_elig  = run && win_found && !full && !bus.drain;
    deq_elig  = run && (bus.q_count != '0);
    contested = enq_elig && deq_elig && bus.deq_ready;
    deq_take  = deq_elig && bus.deq_ready && !(contested && pri_q);
    enq_take  = enq_elig && !deq_take;

    if (contested) pri_d = !pri_q;

    if (enq_take) begin
      enq_ready_w[win_idx] = 1'b1;
      inp_data_w = bus.enq_data[32'(win_idx)*DW +: DW];
      rr_ptr_d   = (win_idx == PW'(NC - 1)) ? '0 : win_idx + 1'b1;
    end

    case (state_q)
      RUN: begin
        if (deq_take && DEQ_GAP > 0) begin
          state_d   = GAP;
          gap_cnt_d = 2'(DEQ_GAP);
        end
      end
      GAP: begin
        if (gap_cnt_q <= 2'd1) begin
          state_d   = RUN;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= RUN;
      gap_cnt_q <= '0;
      pri_q     <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pri_q     <= pri_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.enq_ready  = enq_ready_w;
  assign bus.deq_valid  = deq_elig;
  assign bus.deq_data   = bus.q_out_data;
  assign bus.q_enq      = enq_take;
  assign bus.q_deq      = deq_take;
  assign bus.q_inp_data = inp_data_w;
  assign bus.drain_done = bus.drain && (bus.q_count == '0) && !rst;

`ifdef PRIOQ_SCHED_STATS_EN
  logic [31:0] stat_enq_q, stat_enq_d;
  logic [31:0] stat_deq_q, stat_deq_d;
  logic [31:0] stat_full_q, stat_full_d;

  always_comb begin
    stat_enq_d  = stat_enq_q;
    stat_deq_d  = stat_deq_q;
    stat_full_d = stat_full_q;
    if (enq_take && stat_enq_q != '1) stat_enq_d = stat_enq_q + 32'd1;
    if (deq_take && stat_deq_q != '1) stat_deq_d = stat_deq_q + 32'd1;
    if ((bus.enq_valid != '0) && full && stat_full_q != '1) stat_full_d = stat_full_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      stat_enq_q  <= '0;
      stat_deq_q  <= '0;
      stat_full_q <= '0;
    end else begin
      stat_enq_q  <= stat_enq_d;
      stat_deq_q  <= stat_deq_d;
      stat_full_q <= stat_full_d;
    end
  end

  assign stat_enq  = stat_enq_q;
  assign stat_deq  = stat_deq_q;
  assign stat_full = stat_full_q;
`endif

endmodule
